// File: rtl/multi_stack_unit.sv
// Per-thread operand-stack store: THREADS independent stacks of DEPTH words with atomic
// stack ops, bounds checking, sticky per-thread faults and hardware scrubbing.
module multi_stack_unit #(
  parameter int unsigned THREADS = 2,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TID_W   = (THREADS > 1) ? $clog2(THREADS) : 1,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [TID_W-1:0]   req_tid,
  input  logic [2:0]         req_op,
  input  logic [CNT_W-2:0]   req_imm,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               rsp_valid,
  output logic [TID_W-1:0]   rsp_tid,
  output logic               rsp_err,
  output logic [WIDTH-1:0]   rsp_data1,
  output logic [WIDTH-1:0]   rsp_data2,
  output logic [CNT_W-1:0]   rsp_cnt,
  output logic [THREADS-1:0] fault
);

  localparam int unsigned IDX_W = CNT_W - 1;
  localparam int unsigned PTR_W = TID_W + IDX_W;
  localparam logic [PTR_W-1:0] LastAll = PTR_W'(THREADS * DEPTH - 1);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] Full    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two     = CNT_W'(2);

  typedef enum logic [2:0] {
    OpNop, OpPush, OpPop, OpGet, OpPut, OpRead2, OpReplace2, OpClr
  } op_e;

  typedef enum logic [1:0] {StScrubAll, StIdle, StScrubT} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   scrub_q, scrub_d;
  logic [TID_W-1:0]   scrub_tid_q, scrub_tid_d;
  logic [CNT_W-1:0]   cnt_q [THREADS];
  logic [CNT_W-1:0]   cnt_d [THREADS];
  logic [THREADS-1:0] fault_q, fault_d;
  logic [WIDTH-1:0]   mem_q [THREADS][DEPTH];

  logic               accept;
  op_e                op;
  logic [CNT_W-1:0]   c, n_ext, cnt_new;
  logic [IDX_W-1:0]   top_idx, sec_idx, src_idx;
  logic [WIDTH-1:0]   top_word, src_word, data1, data2;
  logic               err;
  logic               we;
  logic [TID_W-1:0]   w_tid;
  logic [IDX_W-1:0]   w_idx;
  logic [WIDTH-1:0]   w_data;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign op        = op_e'(req_op);
  assign fault     = fault_q;

  // Pre-op operand reads; indices are truncated but only used when c is large enough.
  assign c        = cnt_q[req_tid];
  assign n_ext    = {1'b0, req_imm};
  assign top_idx  = IDX_W'(c - One);
  assign sec_idx  = IDX_W'(c - Two);
  assign src_idx  = IDX_W'(c - n_ext - One);
  assign top_word = mem_q[req_tid][top_idx];
  assign src_word = mem_q[req_tid][src_idx];
  assign data2    = (c >= One) ? top_word : '0;
  assign data1    = (c >= Two) ? mem_q[req_tid][sec_idx] : '0;

  always_comb begin
    state_d     = state_q;
    scrub_d     = scrub_q;
    scrub_tid_d = scrub_tid_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    we          = 1'b0;
    w_tid       = req_tid;
    w_idx       = '0;
    w_data      = req_wdata;
    err         = 1'b0;
    cnt_new     = c;

    unique case (state_q)
      StScrubAll: begin
        we     = 1'b1;
        w_tid  = scrub_q[PTR_W-1 -: TID_W];
        w_idx  = scrub_q[IDX_W-1:0];
        w_data = '0;
        if (scrub_q == LastAll) begin
          scrub_d = '0;
          state_d = StIdle;
        end else begin
          scrub_d = scrub_q + PTR_W'(1);
        end
      end
      StScrubT: begin
        we     = 1'b1;
        w_tid  = scrub_tid_q;
        w_idx  = scrub_q[IDX_W-1:0];
        w_data = '0;
        if (scrub_q[IDX_W-1:0] == LastIdx) begin
          scrub_d = '0;
          state_d = StIdle;
        end else begin
          scrub_d = scrub_q + PTR_W'(1);
        end
      end
      default: begin
        if (accept) begin
          if (fault_q[req_tid] && op != OpNop && op != OpClr) begin
            err = 1'b1;
          end else begin
            unique case (op)
              OpNop: ;
              OpPush: begin
                if (c == Full) begin
                  err = 1'b1;
                end else begin
                  we      = 1'b1;
                  w_idx   = IDX_W'(c);
                  cnt_new = c + One;
                end
              end
              OpPop: begin
                if (n_ext > c) begin
                  err     = 1'b1;
                  cnt_new = '0;
                end else begin
                  cnt_new = c - n_ext;
                end
              end
              OpGet: begin
                if (n_ext >= c || c == Full) begin
                  err = 1'b1;
                end else begin
                  we      = 1'b1;
                  w_idx   = IDX_W'(c);
                  w_data  = src_word;
                  cnt_new = c + One;
                end
              end
              OpPut: begin
                if (n_ext >= c) begin
                  err = 1'b1;
                end else begin
                  we     = 1'b1;
                  w_idx  = src_idx;
                  w_data = top_word;
                end
              end
              OpRead2: begin
                err = (c < Two);
              end
              OpReplace2: begin
                if (c < Two) begin
                  err = 1'b1;
                end else begin
                  we      = 1'b1;
                  w_idx   = sec_idx;
                  cnt_new = c - One;
                end
              end
              OpClr: begin
                cnt_new          = '0;
                fault_d[req_tid] = 1'b0;
                scrub_tid_d      = req_tid;
                scrub_d          = '0;
                state_d          = StScrubT;
              end
              default: ;
            endcase
          end
          cnt_d[req_tid] = cnt_new;
          if (err) begin
            fault_d[req_tid] = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StScrubAll;
      scrub_q     <= '0;
      scrub_tid_q <= '0;
      cnt_q       <= '{default: '0};
      fault_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_tid     <= '0;
      rsp_err     <= 1'b0;
      rsp_data1   <= '0;
      rsp_data2   <= '0;
      rsp_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      scrub_q     <= scrub_d;
      scrub_tid_q <= scrub_tid_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      rsp_valid   <= accept;
      if (accept) begin
        rsp_tid   <= req_tid;
        rsp_err   <= err;
        rsp_data1 <= data1;
        rsp_data2 <= data2;
        rsp_cnt   <= cnt_new;
      end
    end
  end

  // Storage has no reset; the scrub sequence clears it after every reset.
  always_ff @(posedge clk) begin
    if (reset && we) begin
      mem_q[w_tid][w_idx] <= w_data;
    end
  end

endmodule

// File: tb/tb_multi_stack_unit.sv
// Directed bench for multi_stack_unit with hand-computed expectations at default parameters.
module tb_multi_stack_unit;

  localparam int unsigned TW = 1;
  localparam int unsigned CW = 9;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, GET = 3'd3, PUT = 3'd4,
                         READ2 = 3'd5, REPL2 = 3'd6, CLR = 3'd7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [TW-1:0] req_tid = '0;
  logic [2:0]    req_op = '0;
  logic [CW-2:0] req_imm = '0;
  logic [15:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tid;
  logic          rsp_err;
  logic [15:0]   rsp_data1;
  logic [15:0]   rsp_data2;
  logic [CW-1:0] rsp_cnt;
  logic [1:0]    fault;

  int n_cmp = 0;
  int n_bad = 0;

  multi_stack_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_tid   (req_tid),
    .req_op    (req_op),
    .req_imm   (req_imm),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_tid   (rsp_tid),
    .rsp_err   (rsp_err),
    .rsp_data1 (rsp_data1),
    .rsp_data2 (rsp_data2),
    .rsp_cnt   (rsp_cnt),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request, accepted on the next posedge; outputs sampled 1ns after that edge.
  task automatic issue(input logic [TW-1:0] tid, input logic [2:0] op,
                       input logic [CW-2:0] imm, input logic [15:0] wd);
    @(negedge clk);
    if (req_ready !== 1'b1) check_eq("ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_tid   = tid;
    req_op    = op;
    req_imm   = imm;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_tid", 32'(rsp_tid), 32'(tid));
  endtask

  task automatic expect_rsp(input string tag, input logic err, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [CW-1:0] cnt);
    check_eq({tag, ".err"}, 32'(rsp_err), 32'(err));
    check_eq({tag, ".d1"}, 32'(rsp_data1), 32'(d1));
    check_eq({tag, ".d2"}, 32'(rsp_data2), 32'(d2));
    check_eq({tag, ".cnt"}, 32'(rsp_cnt), 32'(cnt));
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int cyc = 0;
    while (req_ready !== 1'b1 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq(tag, 32'(cyc), 32'(exp_cycles));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, ".valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".err"}, 32'(rsp_err), 32'd0);
    check_eq({tag, ".fault"}, 32'(fault), 32'd0);
    check_eq({tag, ".cnt"}, 32'(rsp_cnt), 32'd0);
    check_eq({tag, ".d1"}, 32'(rsp_data1), 32'd0);
    check_eq({tag, ".d2"}, 32'(rsp_data2), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;
    wait_ready("scrub_all_cycles", 512);

    issue(0, READ2, 0, 0);
    expect_rsp("read2_empty", 1'b1, 16'h0, 16'h0, 9'd0);
    check_eq("fault_after_read2", 32'(fault), 32'h1);
    issue(0, NOP, 0, 0);
    expect_rsp("nop", 1'b0, 16'h0, 16'h0, 9'd0);
    issue(0, CLR, 0, 0);
    expect_rsp("clr_t0", 1'b0, 16'h0, 16'h0, 9'd0);
    check_eq("fault_after_clr", 32'(fault), 32'h0);
    wait_ready("scrub_t0_cycles", 256);

    // Basic push / read / replace on t0.
    issue(0, PUSH, 0, 16'h0011);
    expect_rsp("push11", 1'b0, 16'h0, 16'h0, 9'd1);
    issue(0, PUSH, 0, 16'h0022);
    expect_rsp("push22", 1'b0, 16'h0, 16'h0011, 9'd2);
    issue(0, READ2, 0, 0);
    expect_rsp("read2_a", 1'b0, 16'h0011, 16'h0022, 9'd2);
    issue(0, REPL2, 0, 16'h0033);
    expect_rsp("replace2", 1'b0, 16'h0011, 16'h0022, 9'd1);
    issue(0, READ2, 0, 0);
    expect_rsp("read2_one", 1'b1, 16'h0, 16'h0033, 9'd1);

    // GET / PUT on t1; t1 memory evolves [A,B,C] -> [A,B,C,A] -> [A,B,A,A].
    issue(1, PUSH, 0, 16'hAAAA);
    issue(1, PUSH, 0, 16'hBBBB);
    issue(1, PUSH, 0, 16'hCCCC);
    expect_rsp("t1_push3", 1'b0, 16'hAAAA, 16'hBBBB, 9'd3);
    issue(1, GET, 2, 0);
    expect_rsp("get2", 1'b0, 16'hBBBB, 16'hCCCC, 9'd4);
    issue(1, READ2, 0, 0);
    expect_rsp("read2_get", 1'b0, 16'hCCCC, 16'hAAAA, 9'd4);
    issue(1, PUT, 3, 0);
    expect_rsp("put3", 1'b0, 16'hCCCC, 16'hAAAA, 9'd4);
    issue(1, PUT, 1, 0);
    expect_rsp("put1", 1'b0, 16'hCCCC, 16'hAAAA, 9'd4);
    issue(1, POP, 1, 0);
    expect_rsp("pop1", 1'b0, 16'hAAAA, 16'hAAAA, 9'd3);
    issue(1, READ2, 0, 0);
    expect_rsp("read2_put", 1'b0, 16'hBBBB, 16'hAAAA, 9'd3);
    issue(0, READ2, 0, 0);
    expect_rsp("t0_untouched", 1'b1, 16'h0, 16'h0033, 9'd1);
    check_eq("fault_t0_only", 32'(fault), 32'h1);

    // Fill t0 to DEPTH, then overflow.
    issue(0, CLR, 0, 0);
    wait_ready("scrub_t0_again", 256);
    for (int i = 0; i < 256; i++) begin
      issue(0, PUSH, 0, 16'h1000 + 16'(i));
      check_eq("fill_err", 32'(rsp_err), 32'd0);
      check_eq("fill_cnt", 32'(rsp_cnt), 32'(i + 1));
    end
    issue(0, PUSH, 0, 16'hFFFF);
    expect_rsp("overflow", 1'b1, 16'h10FE, 16'h10FF, 9'd256);
    check_eq("fault_overflow", 32'(fault), 32'h1);
    issue(0, POP, 1, 0);
    expect_rsp("pop_faulted", 1'b1, 16'h10FE, 16'h10FF, 9'd256);
    issue(1, PUSH, 0, 16'hDDDD);
    expect_rsp("t1_push_ok", 1'b0, 16'hBBBB, 16'hAAAA, 9'd4);

    // Underflow on t1, then clear it.
    issue(1, POP, 1, 0);
    expect_rsp("t1_pop1", 1'b0, 16'hAAAA, 16'hDDDD, 9'd3);
    issue(1, POP, 5, 0);
    expect_rsp("underflow", 1'b1, 16'hBBBB, 16'hAAAA, 9'd0);
    check_eq("fault_both", 32'(fault), 32'h3);
    issue(1, CLR, 0, 0);
    expect_rsp("clr_t1", 1'b0, 16'h0, 16'h0, 9'd0);
    check_eq("fault_t1_cleared", 32'(fault), 32'h1);
    check_eq("ready_low_scrub_t", 32'(req_ready), 32'd0);
    wait_ready("scrub_t1_cycles", 256);
    issue(1, PUSH, 0, 16'h5555);
    expect_rsp("t1_after_clr", 1'b0, 16'h0, 16'h0, 9'd1);
    issue(0, READ2, 0, 0);
    expect_rsp("t0_intact", 1'b1, 16'h10FE, 16'h10FF, 9'd256);

    // Reset in the middle of a thread scrub.
    issue(0, CLR, 0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("mid_scrub_reset");
    @(negedge clk);
    reset = 1'b1;
    wait_ready("scrub_all_restart", 512);
    issue(0, READ2, 0, 0);
    expect_rsp("read2_after_rst", 1'b1, 16'h0, 16'h0, 9'd0);
    issue(1, READ2, 0, 0);
    expect_rsp("t1_after_rst", 1'b1, 16'h0, 16'h0, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
